// File: rtl/sal_ref_ctrl.sv
// Periodic DRAM auto-refresh controller: tREFI interval ticks, postponed-refresh
// accounting, and a req/gnt handshake followed by a tRFC busy window.
module sal_ref_ctrl #(
  parameter int TREFI_W      = 16,
  parameter int TRFC_W       = 8,
  parameter int MAX_POSTPONE = 8,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ref_en_i,
  input  logic [TREFI_W-1:0] trefi_i,
  input  logic [TRFC_W-1:0]  trfc_i,
  output logic               ref_req_o,
  input  logic               ref_gnt_i,
  output logic               ref_busy_o,
  output logic [CNT_W-1:0]   pending_o,
  output logic               urgent_o,
  output logic               ovf_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RFC  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PEND_MAX = CNT_W'(MAX_POSTPONE);

  state_t              state;
  logic [TREFI_W-1:0]  icnt;
  logic [TRFC_W-1:0]   rcnt;
  logic [TRFC_W-1:0]   rcnt_load;
  logic [CNT_W-1:0]    pending;
  logic [CNT_W-1:0]    pend_nxt;
  logic                ival_on;
  logic                tick;
  logic                grant;
  logic                sat;

  // Handshake: ref_req_o is high exactly while in REQ; a cycle with
  // ref_req_o=1 and ref_gnt_i=1 is one accepted REF. Grants at any other
  // time are ignored.
  assign ival_on   = ref_en_i && (trefi_i != '0);
  // >= rather than == so a mid-interval shrink of trefi_i ticks immediately.
  assign tick      = ival_on && (icnt >= (trefi_i - TREFI_W'(1)));
  assign grant     = (state == REQ) && ref_gnt_i;
  assign rcnt_load = (trfc_i == '0) ? '0 : (trfc_i - TRFC_W'(1));
  assign pending_o = pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      icnt <= '0;
    end else if (!ival_on || tick) begin
      icnt <= '0;
    end else begin
      icnt <= icnt + TREFI_W'(1);
    end
  end

  always_comb begin
    pend_nxt = pending;
    sat      = 1'b0;
    if (tick && !grant) begin
      if (pending == PEND_MAX) begin
        sat = 1'b1;
      end else begin
        pend_nxt = pending + CNT_W'(1);
      end
    end else if (grant && !tick && (pending != '0)) begin
      pend_nxt = pending - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending  <= '0;
      urgent_o <= 1'b0;
      ovf_o    <= 1'b0;
    end else begin
      pending  <= pend_nxt;
      urgent_o <= (pend_nxt == PEND_MAX);
      if (sat) begin
        ovf_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rcnt       <= '0;
      ref_req_o  <= 1'b0;
      ref_busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_en_i && (pending != '0)) begin
            state     <= REQ;
            ref_req_o <= 1'b1;
          end
        end
        REQ: begin
          // A grant in the same cycle as an enable drop still issued a REF.
          if (ref_gnt_i) begin
            state      <= RFC;
            rcnt       <= rcnt_load;
            ref_req_o  <= 1'b0;
            ref_busy_o <= 1'b1;
          end else if (!ref_en_i) begin
            state     <= IDLE;
            ref_req_o <= 1'b0;
          end
        end
        RFC: begin
          if (rcnt == '0) begin
            ref_busy_o <= 1'b0;
            if (ref_en_i && (pending != '0)) begin
              state     <= REQ;
              ref_req_o <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            rcnt <= rcnt - TRFC_W'(1);
          end
        end
        default: begin
          state      <= IDLE;
          ref_req_o  <= 1'b0;
          ref_busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sal_ref_ctrl.sv
// Bench for sal_ref_ctrl: directed scenarios plus a randomized run, all
// cross-checked every cycle against a behavioural refresh model.
module tb_sal_ref_ctrl;

  localparam int TREFI_W = 16;
  localparam int TRFC_W  = 8;
  localparam int MAXP    = 8;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ref_en;
  logic [TREFI_W-1:0] trefi;
  logic [TRFC_W-1:0]  trfc;
  logic               ref_gnt;
  logic               ref_req;
  logic               ref_busy;
  logic [CNT_W-1:0]   pending;
  logic               urgent;
  logic               ovf;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed cycles in the interval, outstanding refreshes,
  // whether a request is showing, and how many busy cycles remain.
  int m_age       = 0;
  int m_pend      = 0;
  bit m_ovf       = 1'b0;
  bit m_req       = 1'b0;
  int m_busy_left = 0;

  sal_ref_ctrl #(
    .TREFI_W(TREFI_W),
    .TRFC_W(TRFC_W),
    .MAX_POSTPONE(MAXP),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ref_en_i(ref_en),
    .trefi_i(trefi),
    .trfc_i(trfc),
    .ref_req_o(ref_req),
    .ref_gnt_i(ref_gnt),
    .ref_busy_o(ref_busy),
    .pending_o(pending),
    .urgent_o(urgent),
    .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit tk;
    bit gr;
    int old_pend;
    if (!rst_n) begin
      m_age       = 0;
      m_pend      = 0;
      m_ovf       = 1'b0;
      m_req       = 1'b0;
      m_busy_left = 0;
    end else begin
      tk       = ref_en && (trefi != 0) && (m_age + 1 >= int'(trefi));
      gr       = m_req && ref_gnt;
      old_pend = m_pend;
      m_age    = (ref_en && (trefi != 0) && !tk) ? m_age + 1 : 0;
      if (tk && !gr) begin
        if (m_pend == MAXP) m_ovf = 1'b1;
        else m_pend++;
      end else if (gr && !tk && m_pend > 0) begin
        m_pend--;
      end
      if (gr) begin
        m_req       = 1'b0;
        m_busy_left = (trfc == 0) ? 1 : int'(trfc);
      end else if (m_req) begin
        m_req = ref_en;
      end else if (m_busy_left > 0) begin
        m_busy_left--;
        if (m_busy_left == 0) m_req = ref_en && (old_pend > 0);
      end else begin
        m_req = ref_en && (old_pend > 0);
      end
    end
  endtask

  task automatic compare_all();
    chk("req", 32'(ref_req), 32'(m_req));
    chk("busy", 32'(ref_busy), 32'(m_busy_left > 0));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("urgent", 32'(urgent), 32'(m_pend == MAXP));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int first_req;
    int first_busy;
    int first_urg;
    int first_ovf;
    int busy_n;
    int hs;
    bit req41;
    bit done;

    rst_n = 1'b0; ref_en = 1'b0; trefi = '0; trfc = '0; ref_gnt = 1'b0;
    step();
    step();
    chk("reset_req", 32'(ref_req), 0);
    chk("reset_busy", 32'(ref_busy), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_flags", 32'({urgent, ovf}), 0);

    // Basic periodic refresh with grant held high.
    rst_n = 1'b1; trefi = 20; trfc = 5; ref_gnt = 1'b1; ref_en = 1'b1;
    first_req = -1; first_busy = -1; busy_n = 0; req41 = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      step();
      if (ref_req && first_req < 0) first_req = c;
      if (ref_busy && first_busy < 0) first_busy = c;
      if (c <= 30 && ref_busy) busy_n++;
      if (c == 41) req41 = ref_req;
    end
    chk("t1_first_req", first_req, 21);
    chk("t1_first_busy", first_busy, 22);
    chk("t1_busy_len", busy_n, 5);
    chk("t1_second_req", 32'(req41), 1);

    // Postponement up to saturation, then drain.
    ref_en = 1'b0; ref_gnt = 1'b0;
    do_reset();
    trefi = 10; trfc = 3; ref_en = 1'b1;
    first_urg = -1; first_ovf = -1;
    for (int c = 1; c <= 95; c++) begin
      step();
      if (urgent && first_urg < 0) first_urg = c;
      if (ovf && first_ovf < 0) first_ovf = c;
    end
    chk("t2_first_urgent", first_urg, 80);
    chk("t2_first_ovf", first_ovf, 90);
    chk("t2_sat_pending", 32'(pending), MAXP);
    trefi = 0; ref_gnt = 1'b1; hs = 0; done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (ref_req) hs++;
      step();
      if (pending == 0 && !ref_busy && !ref_req) done = 1'b1;
    end
    chk("t2_drain_done", 32'(done), 1);
    chk("t2_handshakes", hs, MAXP);
    chk("t2_ovf_sticky", 32'(ovf), 1);

    // Tick and grant land in the same cycle.
    ref_en = 1'b0; ref_gnt = 1'b0;
    do_reset();
    trefi = 10; trfc = 2; ref_en = 1'b1;
    repeat (29) step();
    chk("t3_pre_pending", 32'(pending), 2);
    chk("t3_pre_req", 32'(ref_req), 1);
    ref_gnt = 1'b1;
    step();
    chk("t3_pending_held", 32'(pending), 2);
    chk("t3_busy", 32'(ref_busy), 1);
    ref_gnt = 1'b0;

    // Enable drop during REQ, then during RFC.
    ref_en = 1'b0;
    do_reset();
    trefi = 10; trfc = 6; ref_en = 1'b1;
    repeat (11) step();
    chk("t4_req_up", 32'(ref_req), 1);
    ref_en = 1'b0;
    step();
    chk("t4_req_withdrawn", 32'(ref_req), 0);
    chk("t4_pending_kept", 32'(pending), 1);
    repeat (15) step();
    chk("t4_no_ticks", 32'(pending), 1);
    ref_en = 1'b1;
    step();
    chk("t4_req_again", 32'(ref_req), 1);
    ref_gnt = 1'b1;
    step();
    busy_n = int'(ref_busy);
    ref_en = 1'b0; ref_gnt = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ref_busy) busy_n++;
    end
    chk("t4_rfc_completes", busy_n, 6);

    // Reset in the middle of the busy window.
    do_reset();
    trefi = 10; trfc = 8; ref_gnt = 1'b1; ref_en = 1'b1;
    repeat (14) step();
    chk("t5_busy_before", 32'(ref_busy), 1);
    rst_n = 1'b0;
    step();
    chk("t5_reset_outputs", 32'({ref_req, ref_busy, pending, urgent, ovf}), 0);
    rst_n = 1'b1;
    first_req = -1;
    for (int c = 1; c <= 30; c++) begin
      step();
      if (ref_req && first_req < 0) first_req = c;
    end
    chk("t5_first_req_after_reset", first_req, 11);

    // trfc_i = 0 yields a single busy cycle.
    ref_en = 1'b0; ref_gnt = 1'b0;
    do_reset();
    trefi = 4; trfc = 0; ref_en = 1'b1; ref_gnt = 1'b1; busy_n = 0;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (ref_busy) busy_n++;
    end
    chk("t6_trfc0_busy", busy_n, 1);

    // trefi_i = 0 produces no ticks.
    ref_en = 1'b0; ref_gnt = 1'b0;
    do_reset();
    trefi = 0; ref_en = 1'b1;
    repeat (50) step();
    chk("t6_trefi0_pending", 32'(pending), 0);

    // Shrinking trefi_i mid-interval ticks on the next edge.
    ref_en = 1'b0;
    do_reset();
    trefi = 100; ref_en = 1'b1;
    repeat (50) step();
    chk("t6_before_shrink", 32'(pending), 0);
    trefi = 5;
    step();
    chk("t6_shrink_tick", 32'(pending), 1);

    // Randomized traffic against the model.
    ref_gnt = 1'b0;
    do_reset();
    trefi = 12; trfc = 3; ref_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      ref_gnt = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) begin
        trefi = TREFI_W'($urandom_range(0, 25));
        trfc  = TRFC_W'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 59) == 0) ref_en = ~ref_en;
      rst_n = ($urandom_range(0, 399) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
